// File: rtl/ov7670_pixel_capture.sv
// ---------------------------------------------------------------------------
// ov7670_pixel_capture
//
// Samples the raw OV7670 camera bus in the system clock domain. It pairs
// bytes into RGB565 pixels, reduces each pixel to RGB444 and writes it to
// the frame buffer together with its address and coordinates.
//
// Parameters
//   H_ACT      active pixels per line
//   V_ACT      active lines per frame
//   ADDR_W     frame-buffer address width (2**ADDR_W >= H_ACT*V_ACT)
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   cam_pclk    in   raw camera pixel clock (sampled as data)
//   cam_vsync   in   raw vsync, high during vertical blanking
//   cam_href    in   raw line-valid
//   cam_data    in   raw camera byte
//   capture_en  in   arms capture of the next frame (looked at in IDLE only)
//   we          out  frame-buffer write strobe, one clk per pixel
//   wAddr       out  write address = y_coor*H_ACT + x_coor
//   wData       out  RGB444 pixel {R4,G4,B4}
//   x_coor      out  column of the current write
//   y_coor      out  row of the current write
//   frame_done  out  one-clk pulse when a captured frame ends
//   line_err    out  sticky: a line ended with an odd byte count
// ---------------------------------------------------------------------------
module ov7670_pixel_capture #(
    parameter int H_ACT  = 320,
    parameter int V_ACT  = 240,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cam_pclk,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_data,
    input  logic              capture_en,
    output logic              we,
    output logic [ADDR_W-1:0] wAddr,
    output logic [11:0]       wData,
    output logic [9:0]        x_coor,
    output logic [8:0]        y_coor,
    output logic              frame_done,
    output logic              line_err
);

    localparam logic [9:0]        H_ACT_C   = 10'(H_ACT);
    localparam logic [8:0]        V_ACT_C   = 9'(V_ACT);
    localparam logic [ADDR_W-1:0] H_ACT_A   = ADDR_W'(H_ACT);
    localparam logic [9:0]        COL_MAX_C = 10'h3FF;
    localparam logic [8:0]        ROW_MAX_C = 9'h1FF;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FRAME = 2'd1,
        CAPTURE    = 2'd2
    } state_t;

    // hi_bits carries {hi[7:4], hi[2:0]}, lo_bits carries {lo[7], lo[4:1]}
    function automatic logic [11:0] rgb565_to_444(input logic [6:0] hi_bits,
                                                  input logic [4:0] lo_bits);
        return {hi_bits[6:3], hi_bits[2:0], lo_bits[4], lo_bits[3:0]};
    endfunction

    // Synchronizer chains; index 1 is the synchronized value, index 2 the
    // one-cycle-older copy used for edge detection.
    logic [2:0] pclk_q;
    logic [2:0] vsync_q;
    logic [2:0] href_q;
    logic [7:0] data_q1;
    logic [7:0] data_q2;

    logic pclk_rise_s;
    logic vsync_rise_s;
    logic vsync_fall_s;
    logic href_fall_s;

    state_t state_q;
    state_t state_d;
    logic   start_capture_s;
    logic   end_frame_s;
    logic   in_capture_s;

    logic              phase_q,      phase_d;
    logic [6:0]        hi_q,         hi_d;
    logic [9:0]        col_q,        col_d;
    logic [8:0]        row_q,        row_d;
    logic [ADDR_W-1:0] row_base_q,   row_base_d;
    logic              we_q,         we_d;
    logic [ADDR_W-1:0] waddr_q,      waddr_d;
    logic [11:0]       wdata_q,      wdata_d;
    logic [9:0]        x_q,          x_d;
    logic [8:0]        y_q,          y_d;
    logic              frame_done_q, frame_done_d;
    logic              line_err_q,   line_err_d;

    // Two-flop synchronizers plus a third stage for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pclk_q  <= 3'b000;
            vsync_q <= 3'b000;
            href_q  <= 3'b000;
            data_q1 <= 8'h00;
            data_q2 <= 8'h00;
        end else begin
            pclk_q  <= {pclk_q[1:0],  cam_pclk};
            vsync_q <= {vsync_q[1:0], cam_vsync};
            href_q  <= {href_q[1:0],  cam_href};
            data_q1 <= cam_data;
            data_q2 <= data_q1;
        end
    end

    assign pclk_rise_s  =  pclk_q[1]  & ~pclk_q[2];
    assign vsync_rise_s =  vsync_q[1] & ~vsync_q[2];
    assign vsync_fall_s = ~vsync_q[1] &  vsync_q[2];
    assign href_fall_s  = ~href_q[1]  &  href_q[2];

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (capture_en) begin
                    state_d = WAIT_FRAME;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_FRAME: begin
                if (vsync_fall_s) begin
                    state_d = CAPTURE;
                end else begin
                    state_d = WAIT_FRAME;
                end
            end
            CAPTURE: begin
                if (vsync_rise_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = CAPTURE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM decoded controls for the datapath
    always_comb begin
        start_capture_s = 1'b0;
        end_frame_s     = 1'b0;
        in_capture_s    = 1'b0;
        case (state_q)
            WAIT_FRAME: start_capture_s = vsync_fall_s;
            CAPTURE: begin
                end_frame_s  = vsync_rise_s;
                in_capture_s = 1'b1;
            end
            default: begin
                start_capture_s = 1'b0;
                end_frame_s     = 1'b0;
                in_capture_s    = 1'b0;
            end
        endcase
    end

    // Byte pairing, counters and write generation
    always_comb begin
        phase_d      = phase_q;
        hi_d         = hi_q;
        col_d        = col_q;
        row_d        = row_q;
        row_base_d   = row_base_q;
        we_d         = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        x_d          = x_q;
        y_d          = y_q;
        line_err_d   = line_err_q;
        frame_done_d = end_frame_s;

        if (start_capture_s) begin
            phase_d    = 1'b0;
            col_d      = 10'd0;
            row_d      = 9'd0;
            row_base_d = '0;
            line_err_d = 1'b0;
        end else if (end_frame_s) begin
            // vsync wins over any concurrent byte: a pending hi is dropped
            phase_d = 1'b0;
        end else if (in_capture_s) begin
            if (href_fall_s) begin
                if (phase_q) begin
                    line_err_d = 1'b1;
                    phase_d    = 1'b0;
                end else begin
                    line_err_d = line_err_q;
                end
                // Empty lines (no completed pixels) do not consume a row
                if (col_q != 10'd0) begin
                    if (row_q != ROW_MAX_C) begin
                        row_d = row_q + 9'd1;
                    end else begin
                        row_d = row_q;
                    end
                    // Row base only matters for in-range rows
                    if (row_q < V_ACT_C) begin
                        row_base_d = row_base_q + H_ACT_A;
                    end else begin
                        row_base_d = row_base_q;
                    end
                end else begin
                    row_d = row_q;
                end
                col_d = 10'd0;
            end else if (pclk_rise_s && href_q[1]) begin
                if (!phase_q) begin
                    hi_d    = {data_q2[7:4], data_q2[2:0]};
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if ((col_q < H_ACT_C) && (row_q < V_ACT_C)) begin
                        we_d    = 1'b1;
                        waddr_d = row_base_q + ADDR_W'(col_q);
                        wdata_d = rgb565_to_444(hi_q, {data_q2[7], data_q2[4:1]});
                        x_d     = col_q;
                        y_d     = row_q;
                    end else begin
                        we_d = 1'b0;
                    end
                    if (col_q != COL_MAX_C) begin
                        col_d = col_q + 10'd1;
                    end else begin
                        col_d = col_q;
                    end
                end
            end else begin
                phase_d = phase_q;
            end
        end else begin
            phase_d = 1'b0;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q      <= 1'b0;
            hi_q         <= 7'd0;
            col_q        <= 10'd0;
            row_q        <= 9'd0;
            row_base_q   <= '0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= 12'h000;
            x_q          <= 10'd0;
            y_q          <= 9'd0;
            frame_done_q <= 1'b0;
            line_err_q   <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            hi_q         <= hi_d;
            col_q        <= col_d;
            row_q        <= row_d;
            row_base_q   <= row_base_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            x_q          <= x_d;
            y_q          <= y_d;
            frame_done_q <= frame_done_d;
            line_err_q   <= line_err_d;
        end
    end

    assign we         = we_q;
    assign wAddr      = waddr_q;
    assign wData      = wdata_q;
    assign x_coor     = x_q;
    assign y_coor     = y_q;
    assign frame_done = frame_done_q;
    assign line_err   = line_err_q;

endmodule
